// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit saturating-counter direction predictor with
// execute-stage training, registered PC redirect, fixed-length flush
// sequencing and saturating branch/mispredict statistics.
module branch_predict_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  input  logic                  if_is_branch_i,
  output logic                  pred_taken_o,
  input  logic                  ex_valid_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_i,
  input  logic                  ex_pred_taken_i,
  input  logic                  ex_branch_taken_i,
  input  logic [DATA_WIDTH-1:0] ex_target_i,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  flush_o,
  output logic [15:0]           branch_count_o,
  output logic [15:0]           mispredict_count_o
);

  localparam int IW  = $clog2(BHT_ENTRIES);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t                  state_reg, state_next;
  logic [FCW-1:0]          flush_cnt_reg, flush_cnt_next;
  logic                    accept, mispredict;
  logic [IW-1:0]           if_idx, ex_idx;
  logic [1:0]              bht_reg [BHT_ENTRIES];
  logic                    redirect_reg;
  logic [DATA_WIDTH-1:0]   redirect_pc_reg, redirect_pc_next;
  logic [15:0]             branch_cnt_reg, mispredict_cnt_reg;
  logic                    unused_pc_bits;

  // Direct-mapped index: word-aligned PC bits, no hashing.
  assign if_idx = if_pc_i[IW+1:2];
  assign ex_idx = ex_pc_i[IW+1:2];
  assign unused_pc_bits = ^{if_pc_i[DATA_WIDTH-1:IW+2], if_pc_i[1:0]};

  // Zero-latency prediction from the pre-update counter (no write bypass).
  assign pred_taken_o = if_is_branch_i & bht_reg[if_idx][1];

  // FSM state register (flush countdown travels with the state).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // FSM next-state: a mispredict in IDLE starts a flush of FLUSH_CYCLES cycles.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mispredict) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == '0) state_next = ST_IDLE;
        else                     flush_cnt_next = flush_cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: resolutions are only honoured in IDLE; anything in FLUSH is squashed.
  always_comb begin
    accept           = ex_valid_i && (state_reg == ST_IDLE);
    mispredict       = accept && (ex_pred_taken_i != ex_branch_taken_i);
    redirect_pc_next = ex_branch_taken_i ? ex_target_i
                                         : ex_pc_i + DATA_WIDTH'(4);
  end

  assign flush_o = (state_reg == ST_FLUSH);

  // Counter table: each entry trains on an accepted resolution at its index.
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          bht_reg[gi] <= 2'b01;
        end else if (accept && (ex_idx == IW'(gi))) begin
          if (ex_branch_taken_i) begin
            if (bht_reg[gi] != 2'b11) bht_reg[gi] <= bht_reg[gi] + 2'b01;
          end else begin
            if (bht_reg[gi] != 2'b00) bht_reg[gi] <= bht_reg[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  // Redirect pulse and held redirect target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      redirect_reg <= mispredict;
      if (mispredict) redirect_pc_reg <= redirect_pc_next;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (accept && (branch_cnt_reg != 16'hFFFF))
        branch_cnt_reg <= branch_cnt_reg + 16'd1;
      if (mispredict && (mispredict_cnt_reg != 16'hFFFF))
        mispredict_cnt_reg <= mispredict_cnt_reg + 16'd1;
    end
  end

  assign redirect_o         = redirect_reg;
  assign redirect_pc_o      = redirect_pc_reg;
  assign branch_count_o     = branch_cnt_reg;
  assign mispredict_count_o = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (32-bit, 16 entries, 2-cycle flush).
module tb_branch_predict_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] if_pc_i;
  logic        if_is_branch_i;
  logic        pred_taken_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_pred_taken_i;
  logic        ex_branch_taken_i;
  logic [31:0] ex_target_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [15:0] branch_count_o;
  logic [15:0] mispredict_count_o;

  int checks = 0;
  int errors = 0;

  branch_predict_unit #(
    .DATA_WIDTH(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_pc_i(if_pc_i), .if_is_branch_i(if_is_branch_i), .pred_taken_o(pred_taken_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_branch_taken_i(ex_branch_taken_i), .ex_target_i(ex_target_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic pred, input logic taken,
                         input logic [31:0] tgt);
    ex_valid_i        = 1'b1;
    ex_pc_i           = pc;
    ex_pred_taken_i   = pred;
    ex_branch_taken_i = taken;
    ex_target_i       = tgt;
  endtask

  task automatic idle_ex;
    ex_valid_i = 1'b0;
  endtask

  task automatic predict_at(input logic [31:0] pc);
    if_pc_i        = pc;
    if_is_branch_i = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; idle_ex(); ex_pc_i = '0; ex_pred_taken_i = 0; ex_branch_taken_i = 0;
    ex_target_i = '0; if_pc_i = '0; if_is_branch_i = 0;
    tick(); tick();
    rst_i = 1'b0;
    predict_at(32'h40);
    checks++;
    if ({pred_taken_o, redirect_o, flush_o} !== 3'b000 || redirect_pc_o !== 32'h0 ||
        branch_count_o !== 16'h0 || mispredict_count_o !== 16'h0) begin
      errors++;
      $display("FAIL reset: pred/redir/flush=%b%b%b pc=%h br=%h mp=%h required all 0",
               pred_taken_o, redirect_o, flush_o, redirect_pc_o, branch_count_o, mispredict_count_o);
    end
    $display("reset: pred=%b redirect=%b flush=%b", pred_taken_o, redirect_o, flush_o);
    if_is_branch_i = 1'b0; #1;
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL pred_not_branch: got %b required 0", pred_taken_o);
    end
  endtask

  task automatic test_train_mispredict;
    predict_at(32'h40);
    resolve(32'h40, 1'b0, 1'b1, 32'h100);
    #1;
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL same_cycle_no_bypass: got %b required 0", pred_taken_o);
    end
    tick(); idle_ex();
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h100 || flush_o !== 1'b1) begin
      errors++;
      $display("FAIL mp1_redirect: redir=%b pc=%h flush=%b required 1 00000100 1",
               redirect_o, redirect_pc_o, flush_o);
    end
    $display("mp1: redirect=%b pc=%h flush=%b", redirect_o, redirect_pc_o, flush_o);
    tick();
    checks++;
    if (redirect_o !== 1'b0 || flush_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL mp1_flush2: redir=%b flush=%b pc=%h required 0 1 00000100",
               redirect_o, flush_o, redirect_pc_o);
    end
    tick();
    checks++;
    if (flush_o !== 1'b0) begin
      errors++; $display("FAIL mp1_flush_end: flush=%b required 0", flush_o);
    end
    // first IDLE cycle after the flush: second resolution accepted
    resolve(32'h40, 1'b0, 1'b1, 32'h200);
    tick(); idle_ex();
    predict_at(32'h40);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200 || flush_o !== 1'b1 ||
        pred_taken_o !== 1'b1) begin
      errors++;
      $display("FAIL mp2_redirect: redir=%b pc=%h flush=%b pred=%b required 1 00000200 1 1",
               redirect_o, redirect_pc_o, flush_o, pred_taken_o);
    end
    checks++;
    if (branch_count_o !== 16'd2 || mispredict_count_o !== 16'd2) begin
      errors++;
      $display("FAIL mp2_counts: br=%0d mp=%0d required 2 2", branch_count_o, mispredict_count_o);
    end
    $display("mp2: redirect=%b pc=%h br=%0d mp=%0d", redirect_o, redirect_pc_o,
             branch_count_o, mispredict_count_o);
    tick(); tick();
  endtask

  task automatic test_correct_prediction;
    resolve(32'h40, 1'b1, 1'b1, 32'h300);
    tick(); idle_ex();
    checks++;
    if (redirect_o !== 1'b0 || flush_o !== 1'b0 || branch_count_o !== 16'd3 ||
        mispredict_count_o !== 16'd2 || redirect_pc_o !== 32'h200) begin
      errors++;
      $display("FAIL correct_pred: redir=%b flush=%b br=%0d mp=%0d pc=%h required 0 0 3 2 00000200",
               redirect_o, flush_o, branch_count_o, mispredict_count_o, redirect_pc_o);
    end
    $display("correct: redirect=%b flush=%b br=%0d", redirect_o, flush_o, branch_count_o);
  endtask

  task automatic test_wrap;
    resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h500);
    tick(); idle_ex();
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0 || mispredict_count_o !== 16'd3) begin
      errors++;
      $display("FAIL nt_wrap: redir=%b pc=%h mp=%0d required 1 00000000 3",
               redirect_o, redirect_pc_o, mispredict_count_o);
    end
    $display("wrap: redirect=%b pc=%h", redirect_o, redirect_pc_o);
    tick(); tick();
  endtask

  task automatic test_counter_saturation;
    // entry for 0x40 is at 11; one not-taken must leave it at weak-taken
    resolve(32'h40, 1'b1, 1'b0, 32'h0);
    tick(); idle_ex(); tick(); tick();
    predict_at(32'h40);
    checks++;
    if (pred_taken_o !== 1'b1) begin
      errors++; $display("FAIL ctr_sat_hi: pred=%b required 1", pred_taken_o);
    end
    resolve(32'h40, 1'b1, 1'b0, 32'h0);
    tick(); idle_ex();
    checks++;
    if (pred_taken_o !== 1'b0 || redirect_pc_o !== 32'h44) begin
      errors++;
      $display("FAIL ctr_dec: pred=%b pc=%h required 0 00000044", pred_taken_o, redirect_pc_o);
    end
    $display("ctr_sat: pred=%b br=%0d mp=%0d", pred_taken_o, branch_count_o, mispredict_count_o);
    tick(); tick();
  endtask

  task automatic test_flush_ignore;
    resolve(32'h20, 1'b0, 1'b1, 32'h300);
    tick();
    // mispredicting resolutions held during both FLUSH cycles must be squashed
    resolve(32'h20, 1'b1, 1'b0, 32'h700);
    checks++;
    if (redirect_o !== 1'b1 || flush_o !== 1'b1 || redirect_pc_o !== 32'h300) begin
      errors++;
      $display("FAIL fi_start: redir=%b flush=%b pc=%h required 1 1 00000300",
               redirect_o, flush_o, redirect_pc_o);
    end
    tick();
    checks++;
    if (redirect_o !== 1'b0 || flush_o !== 1'b1) begin
      errors++; $display("FAIL fi_mid: redir=%b flush=%b required 0 1", redirect_o, flush_o);
    end
    tick(); idle_ex();
    predict_at(32'h20);
    checks++;
    if (redirect_o !== 1'b0 || flush_o !== 1'b0 || redirect_pc_o !== 32'h300 ||
        pred_taken_o !== 1'b1 || branch_count_o !== 16'd7 || mispredict_count_o !== 16'd6) begin
      errors++;
      $display("FAIL fi_end: redir=%b flush=%b pc=%h pred=%b br=%0d mp=%0d required 0 0 00000300 1 7 6",
               redirect_o, flush_o, redirect_pc_o, pred_taken_o, branch_count_o, mispredict_count_o);
    end
    $display("flush_ignore: flush=%b br=%0d mp=%0d", flush_o, branch_count_o, mispredict_count_o);
  endtask

  task automatic test_alias;
    predict_at(32'h80);
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL alias_before: pred=%b required 0", pred_taken_o);
    end
    resolve(32'h40, 1'b0, 1'b1, 32'h800);
    tick(); idle_ex();
    predict_at(32'h80);
    checks++;
    if (pred_taken_o !== 1'b1) begin
      errors++; $display("FAIL alias_after: pred=%b required 1", pred_taken_o);
    end
    $display("alias: pred(0x80)=%b", pred_taken_o);
    tick(); tick();
  endtask

  task automatic test_stat_saturation;
    force dut.mispredict_cnt_reg = 16'hFFFE;
    #1;
    release dut.mispredict_cnt_reg;
    resolve(32'h40, 1'b0, 1'b1, 32'h900);
    tick(); idle_ex();
    checks++;
    if (mispredict_count_o !== 16'hFFFF || branch_count_o !== 16'd9) begin
      errors++;
      $display("FAIL stat_reach: mp=%h br=%0d required ffff 9", mispredict_count_o, branch_count_o);
    end
    tick(); tick();
    resolve(32'h40, 1'b0, 1'b1, 32'hA00);
    tick(); idle_ex();
    checks++;
    if (mispredict_count_o !== 16'hFFFF || branch_count_o !== 16'd10 || redirect_o !== 1'b1) begin
      errors++;
      $display("FAIL stat_hold: mp=%h br=%0d redir=%b required ffff 10 1",
               mispredict_count_o, branch_count_o, redirect_o);
    end
    $display("stat_sat: mp=%h br=%0d", mispredict_count_o, branch_count_o);
  endtask

  task automatic test_reset_mid_flush;
    tick();
    checks++;
    if (flush_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre: flush=%b required 1", flush_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (flush_o !== 1'b0 || redirect_pc_o !== 32'h0 || mispredict_count_o !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_flush: flush=%b pc=%h mp=%h required 0 0 0",
               flush_o, redirect_pc_o, mispredict_count_o);
    end
    $display("reset_mid_flush: flush=%b", flush_o);
  endtask

  initial begin
    test_reset();
    test_train_mispredict();
    test_correct_prediction();
    test_wrap();
    test_counter_saturation();
    test_flush_ignore();
    test_alias();
    test_stat_saturation();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Branch prediction and redirect controller for the pipelined core. It holds a table of 2-bit saturating counters that predicts branch direction at fetch. It trains the table with the resolved outcome from the execute-stage branch comparator. On a misprediction it sequences a registered PC redirect and a fixed-length pipeline flush, and keeps saturating statistics counters.

## Interface
- DATA_WIDTH, 32: PC/target width (from defines).
- BHT_ENTRIES, 16: counter table depth; power of two, ≥2.
- FLUSH_CYCLES, 2: cycles flush_o stays high per mispredict; ≥1.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- if_pc_i  input  DATA_WIDTH  fetch PC.
- if_is_branch_i  input  1  fetch instruction is a conditional branch.
- pred_taken_o  output  1  fetch prediction; combinational.
- ex_valid_i  input  1  resolved conditional branch in execute (Branch_i qualified by valid).
- ex_pc_i  input  DATA_WIDTH  PC of the resolving branch.
- ex_pred_taken_i  input  1  prediction carried down the pipe with the branch.
- ex_branch_taken_i  input  1  actual outcome from the branch comparator.
- ex_target_i  input  DATA_WIDTH  computed branch target.
- redirect_o  output  1  one-cycle pulse: load redirect_pc_o into PC.
- redirect_pc_o  output  DATA_WIDTH  correct next PC.
- flush_o  output  1  squash younger IF/ID/EX instructions.
- branch_count_o  output  16  resolved branches, saturating.
- mispredict_count_o  output  16  mispredictions, saturating.

## Operation
- Index width: IW = log2(BHT_ENTRIES). Index = pc[IW+1:2], with no hashing.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken.
  - 10 = weak taken, 11 = strong taken.
  - Prediction is counter[1].
- pred_taken_o = if_is_branch_i & counter[idx(if_pc_i)][1]. It is 0 when if_is_branch_i = 0.
- Training: an accepted ex_valid_i updates counter[idx(ex_pc_i)].
  - Increments when ex_branch_taken_i = 1, saturating at 11.
  - Decrements otherwise, saturating at 00.
- Mispredict: mispredict = accepted ex_valid_i & (ex_pred_taken_i != ex_branch_taken_i).
- redirect_pc_o:
  - ex_target_i if the branch was actually taken.
  - ex_pc_i + 4 otherwise, modulo 2^DATA_WIDTH.
- FSM states:
  - IDLE: ex_valid_i is accepted. A mispredict goes to FLUSH and loads flush_cnt = FLUSH_CYCLES-1. A correct prediction stays in IDLE.
  - FLUSH: ex_valid_i is ignored (the instruction is squashed): no training, no counting, no redirect. When flush_cnt = 0, go to IDLE; otherwise decrement.
- Statistics:
  - branch_count_o increments on every accepted ex_valid_i.
  - mispredict_count_o increments on every mispredict.
  - Both hold at 16'hFFFF.

## Timing
- Reset values:
  - All counters = 01.
  - FSM = IDLE, flush_cnt = 0.
  - redirect_o = 0, redirect_pc_o = 0, flush_o = 0.
  - Both statistics counters = 0.
- Reset mid-FLUSH aborts the flush immediately: flush_o = 0 the next cycle.
- Prediction latency is zero: pred_taken_o follows if_pc_i in the same cycle.
- Training, redirect and flush are registered with latency 1.
  - A mispredict sampled at edge N gives redirect_o = 1 and flush_o = 1 in cycle N+1, with redirect_pc_o valid in that cycle.
  - redirect_o is high exactly one cycle. flush_o is high exactly FLUSH_CYCLES consecutive cycles.
- redirect_pc_o holds its last value when redirect_o = 0.
- Same-cycle read/write of one entry: pred_taken_o uses the pre-update value. The new value is visible the next cycle (no bypass).
- A mispredict on the cycle that FLUSH returns to IDLE is ignored. The FSM is still in FLUSH at that edge.
- A branch arriving the first IDLE cycle after a flush is accepted normally.

## Test plan
- Reset, then if_pc_i = 0x40 with if_is_branch_i = 1 -> pred_taken_o = 0; all outputs and counts 0.
- Train pc 0x40 taken twice, both with ex_pred_taken_i = 0 and FLUSH_CYCLES = 2:
  - First resolution -> redirect_o pulse, redirect_pc_o = target, flush_o high 2 cycles.
  - Second resolution, issued in the first IDLE cycle after the flush -> second redirect; pred_taken_o for 0x40 = 1.
  - Counts: branch = 2, mispredict = 2.
- Correct prediction: counter 11, taken, ex_pred_taken_i = 1 -> no redirect, no flush, counter stays 11, branch_count_o +1.
- Not-taken mispredict: ex_pc_i = 0xFFFFFFFC, predicted taken, actual not taken -> redirect_pc_o = 0x00000000 (wrap).
- ex_valid_i mispredict asserted during both FLUSH cycles -> ignored; no counter change; flush_o length unchanged.
- Aliasing: 0x40 and 0x80 share an index at BHT_ENTRIES = 16 -> training one changes the other's prediction.
- Saturation: preload mispredict_count_o = 16'hFFFF, then mispredict -> count holds 16'hFFFF.
